// File: rtl/bcd_display_scanner.sv
// ============================================================================
//  Module   : bcd_display_scanner
//  Purpose  : Time-multiplexed scan driver for a common-cathode 7-segment
//             display, with ghosting guard, digit blanking and frame-aligned
//             word updates through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   load_valid,
   output logic                                                   load_ready,
   input  logic [4*NUM_DIGITS-1:0]                                load_bcd,
   input  logic                                                   blank_lz,
   output logic [3:0]                                             bcd_out,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
   output logic [NUM_DIGITS-1:0]                                  digit_en,
   output logic                                                   frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int WORD_W = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_W-1:0]     active_q, active_d;
   logic [WORD_W-1:0]     pending_q, pending_d;
   logic                  pending_full_q, pending_full_d;
   logic                  slot_blank_q, slot_blank_d;
   logic [3:0]            bcd_out_q, bcd_out_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
   logic                  frame_done_q, frame_done_d;

   logic                  cnt_wrap;
   logic                  idx_last;
   logic                  boundary;
   logic                  xfer;
   logic                  run_zero;
   logic                  sel_lz;
   logic [3:0]            sel_nib;
   logic                  new_blank;
   logic                  slot_start;

   always_comb begin
      cnt_wrap = (cnt_q == CNT_LAST);
      idx_last = (idx_q == IDX_LAST);
      boundary = cnt_wrap && idx_last;
      xfer     = load_valid && !pending_full_q;

      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_wrap) begin
         idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
      end

      active_d       = (boundary && pending_full_q) ? pending_q : active_q;
      pending_d      = xfer ? load_bcd : pending_q;
      pending_full_d = pending_full_q;
      if (boundary && pending_full_q) begin
         pending_full_d = 1'b0;
      end else if (xfer) begin
         pending_full_d = 1'b1;
      end
   end

   // Slot attributes are evaluated from next-state values, so the registered
   // outputs line up with cnt/idx and stay frozen for the whole slot.
   always_comb begin
      run_zero = 1'b1;
      sel_nib  = 4'd0;
      sel_lz   = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         run_zero = run_zero && (active_d[4*k +: 4] == 4'd0);
         if (idx_d == IDX_W'(k)) begin
            sel_nib = active_d[4*k +: 4];
            sel_lz  = run_zero && (k != 0);
         end
      end
      new_blank  = (sel_nib > 4'd9) || (blank_lz && sel_lz);
      slot_start = (cnt_d == '0);

      slot_blank_d = slot_start ? new_blank : slot_blank_q;
      bcd_out_d    = bcd_out_q;
      if (slot_start) begin
         bcd_out_d = new_blank ? 4'd0 : sel_nib;
      end

      digit_en_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit_en_d[k] = (cnt_d >= CNT_SHOW) && !slot_blank_d && (idx_d == IDX_W'(k));
      end
      frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         idx_q          <= '0;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         slot_blank_q   <= 1'b0;
         bcd_out_q      <= 4'd0;
         digit_en_q     <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         slot_blank_q   <= slot_blank_d;
         bcd_out_q      <= bcd_out_d;
         digit_en_q     <= digit_en_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign load_ready = !pending_full_q;
   assign bcd_out    = bcd_out_q;
   assign digit_idx  = idx_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
//  Module   : tb_bcd_display_scanner
//  Purpose  : Directed self-checking bench for bcd_display_scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scanner;

   localparam int N     = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = N * RD;

   logic          clk;
   logic          rst_n;
   logic          load_valid;
   logic          load_ready;
   logic [15:0]   load_bcd;
   logic          blank_lz;
   logic [3:0]    bcd_out;
   logic [1:0]    digit_idx;
   logic [3:0]    digit_en;
   logic          frame_done;

   int            n_tests;
   int            n_fail;
   int            frames_done;
   bit            exp_full;
   bit            hs_armed;
   logic [15:0]   tx_q[$];

   bcd_display_scanner #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_bcd   (load_bcd),
      .blank_lz   (blank_lz),
      .bcd_out    (bcd_out),
      .digit_idx  (digit_idx),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " digit_en"},   {28'd0, digit_en},   32'd0);
      chk({tag, " bcd_out"},    {28'd0, bcd_out},    32'd0);
      chk({tag, " digit_idx"},  {30'd0, digit_idx},  32'd0);
      chk({tag, " frame_done"}, {31'd0, frame_done}, 32'd0);
      chk({tag, " load_ready"}, {31'd0, load_ready}, 32'd1);
   endtask

   // Entered at the falling edge of frame cycle 0; exp_bcd/exp_mask are the
   // hand-derived per-slot decoder values and enabled slots for this frame.
   task automatic run_frame(input string tag, input logic [15:0] exp_bcd,
                            input logic [3:0] exp_mask, input int tx_from,
                            input logic lz_next, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         int         slot;
         int         phase;
         logic [3:0] e_en;
         logic [3:0] e_bcd;
         slot  = c / RD;
         phase = c % RD;
         if (c == 0 && frames_done > 0) exp_full = 1'b0;
         if (hs_armed) begin
            exp_full   = 1'b1;
            load_valid = 1'b0;
            hs_armed   = 1'b0;
         end
         e_bcd = exp_bcd[4*slot +: 4];
         e_en  = (phase >= BC && exp_mask[slot]) ? (4'b0001 << slot) : 4'b0000;
         chk($sformatf("%s c%0d digit_en", tag, c),   {28'd0, digit_en},   {28'd0, e_en});
         chk($sformatf("%s c%0d bcd_out", tag, c),    {28'd0, bcd_out},    {28'd0, e_bcd});
         chk($sformatf("%s c%0d digit_idx", tag, c),  {30'd0, digit_idx},  slot);
         chk($sformatf("%s c%0d frame_done", tag, c), {31'd0, frame_done}, (c == FRAME - 1) ? 1 : 0);
         chk($sformatf("%s c%0d load_ready", tag, c), {31'd0, load_ready}, exp_full ? 0 : 1);
         if (c == FRAME - 1) blank_lz = lz_next;
         if (!load_valid && tx_q.size() > 0 && c >= tx_from) begin
            load_bcd   = tx_q.pop_front();
            load_valid = 1'b1;
         end
         hs_armed = load_valid && load_ready;
         @(negedge clk);
      end
      if (ncyc == FRAME) frames_done++;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      frames_done = 0;
      exp_full    = 1'b0;
      hs_armed    = 1'b0;
      rst_n       = 1'b0;
      load_valid  = 1'b0;
      load_bcd    = 16'h0000;
      blank_lz    = 1'b0;

      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;

      tx_q.push_back(16'h1234);
      run_frame("f0_idle", 16'h0000, 4'b1111, 3, 1'b0, FRAME);
      tx_q.push_back(16'h0050);
      run_frame("f1_1234", 16'h1234, 4'b1111, 3, 1'b1, FRAME);
      tx_q.push_back(16'h0000);
      run_frame("f2_lz0050", 16'h0050, 4'b0011, 3, 1'b1, FRAME);
      tx_q.push_back(16'h0050);
      run_frame("f3_lz0000", 16'h0000, 4'b0001, 3, 1'b0, FRAME);
      tx_q.push_back(16'h1A2F);
      run_frame("f4_0050", 16'h0050, 4'b1111, 3, 1'b0, FRAME);
      tx_q.push_back(16'h1111);
      tx_q.push_back(16'h2222);
      run_frame("f5_1a2f", 16'h1020, 4'b1010, 2, 1'b0, FRAME);
      run_frame("f6_1111", 16'h1111, 4'b1111, 0, 1'b0, FRAME);
      tx_q.push_back(16'h3333);
      run_frame("f7_2222", 16'h2222, 4'b1111, FRAME - 1, 1'b0, FRAME);
      run_frame("f8_2222", 16'h2222, 4'b1111, 0, 1'b0, FRAME);
      tx_q.push_back(16'h4444);
      run_frame("f9_3333", 16'h3333, 4'b1111, 1, 1'b0, 21);

      // Now in the SHOW phase of slot 2 with 0x4444 pending.
      rst_n      = 1'b0;
      load_valid = 1'b0;
      hs_armed   = 1'b0;
      tx_q.delete();
      @(negedge clk);
      chk_reset("mid_rst");
      @(negedge clk);
      rst_n       = 1'b1;
      exp_full    = 1'b0;
      frames_done = 0;
      run_frame("post_rst0", 16'h0000, 4'b1111, 0, 1'b0, FRAME);
      run_frame("post_rst1", 16'h0000, 4'b1111, 0, 1'b0, FRAME);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
